// File: rtl/jepardy_pkg.sv
// rtl/jepardy_pkg.sv - shared types and constants for the question-round controller
//
// Purpose: state encoding, player count, one-hot player constants and the
//          round-robin successor helper shared by the controller and arbiter.
// Ports:   none (package).

package jepardy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_ANSWER = 2'b10
    } state_e;

    localparam int NUM_PLAYERS = 3;

    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b010;
    localparam logic [2:0] P3 = 3'b100;

    localparam logic [2:0] ALL_PLAYERS = P1 | P2 | P3;

    // Player index that follows idx in the round-robin order, wrapping 3->1.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational three-way round-robin arbiter
//
// Purpose: pick one requester, searching from the pointer position upward
//          with wrap-around. No state; the pointer is owned by the caller.
// Ports:
//   req_i        3-bit request vector, bit i = player i+1
//   ptr_i        2-bit index where the search starts (code 3 behaves as 0)
//   grant_o      3-bit one-hot grant, 000 when nothing is requested
//   grant_idx_o  2-bit index of the granted player (0 when no grant)

module rr_arbiter3
    import jepardy_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_o,
    output logic [1:0] grant_idx_o
);

    logic [1:0] c0, c1, c2;

    always_comb begin
        c0 = (ptr_i == 2'd3) ? 2'd0 : ptr_i;
        c1 = next_idx(c0);
        c2 = next_idx(c1);

        grant_idx_o = 2'd0;
        if (req_i[c0]) begin
            grant_idx_o = c0;
        end else if (req_i[c1]) begin
            grant_idx_o = c1;
        end else if (req_i[c2]) begin
            grant_idx_o = c2;
        end

        grant_o = 3'b000;
        if (|req_i) begin
            case (grant_idx_o)
                2'd0:    grant_o = P1;
                2'd1:    grant_o = P2;
                default: grant_o = P3;
            endcase
        end
    end

endmodule

// File: rtl/jepardy_round_ctrl.sv
// rtl/jepardy_round_ctrl.sv - three-player buzzer question-round controller
//
// Purpose: host arms a question, eligible buzzers are arbitrated round-robin,
//          the winner gets a timed answer window, the host judges it. Wrong
//          or timed-out players are barred for the rest of the question.
//          Saturating per-player scores are kept. All outputs are registered.
// Ports:
//   clock         game clock
//   reset         synchronous active-high reset
//   arm           host starts a question (IDLE only)
//   P_button[2:0] player buttons, bit i = player i+1
//   judge_ok      host: answer correct
//   judge_wrong   host: answer wrong
//   clear_scores  host: zero all scores (IDLE only, loses to arm)
//   lights[2:0]   one-hot current answerer
//   lockout[2:0]  players barred this question
//   busy          high while OPEN or ANSWER
//   scores        {score3, score2, score1}

module jepardy_round_ctrl
    import jepardy_pkg::*;
#(
    parameter int ANSWER_TICKS = 500,
    parameter int OPEN_TICKS   = 1000,
    parameter int SCORE_W      = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           arm,
    input  logic [2:0]                     P_button,
    input  logic                           judge_ok,
    input  logic                           judge_wrong,
    input  logic                           clear_scores,
    output logic [2:0]                     lights,
    output logic [2:0]                     lockout,
    output logic                           busy,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

    localparam int MAX_TICKS = (ANSWER_TICKS > OPEN_TICKS) ? ANSWER_TICKS : OPEN_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    // The timer is loaded with N-1 on the entry edge and expires on the edge
    // where it reads zero, i.e. exactly N edges after entry.
    localparam logic [TW-1:0] ANSWER_LOAD = TW'(ANSWER_TICKS - 1);
    localparam logic [TW-1:0] OPEN_LOAD   = TW'(OPEN_TICKS - 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_e                         state_q, state_d;
    logic [2:0]                     lights_q, lights_d;
    logic [2:0]                     lockout_q, lockout_d;
    logic                           busy_q, busy_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic [1:0]                     ptr_q, ptr_d;
    logic [1:0]                     win_q, win_d;

    logic [2:0] eligible;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic [2:0] lock_after_wrong;

    assign eligible         = P_button & ~lockout_q;
    assign lock_after_wrong = lockout_q | lights_q;

    rr_arbiter3 u_arb (
        .req_i       (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        lights_d  = lights_q;
        lockout_d = lockout_q;
        scores_d  = scores_q;
        timer_d   = timer_q;
        ptr_d     = ptr_q;
        win_d     = win_q;

        case (state_q)
            ST_IDLE: begin
                lights_d = 3'b000;
                if (arm) begin
                    state_d   = ST_OPEN;
                    lockout_d = 3'b000;
                    timer_d   = OPEN_LOAD;
                end else if (clear_scores) begin
                    scores_d = '0;
                end
            end

            ST_OPEN: begin
                lights_d = 3'b000;
                if (lockout_q == ALL_PLAYERS) begin
                    state_d = ST_IDLE;
                end else if (|eligible) begin
                    // A press on the expiry edge still counts as a press.
                    state_d  = ST_ANSWER;
                    lights_d = grant;
                    win_d    = grant_idx;
                    ptr_d    = next_idx(grant_idx);
                    timer_d  = ANSWER_LOAD;
                end else if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_ANSWER: begin
                if (judge_ok) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (win_q == 2'(i) && scores_q[i*SCORE_W +: SCORE_W] != SCORE_MAX) begin
                            scores_d[i*SCORE_W +: SCORE_W] =
                                scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
                        end
                    end
                    state_d  = ST_IDLE;
                    lights_d = 3'b000;
                end else if (judge_wrong || timer_q == '0) begin
                    lockout_d = lock_after_wrong;
                    lights_d  = 3'b000;
                    if (lock_after_wrong == ALL_PLAYERS) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OPEN;
                        timer_d = OPEN_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                lights_d = 3'b000;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lights_q  <= 3'b000;
            lockout_q <= 3'b000;
            busy_q    <= 1'b0;
            scores_q  <= '0;
            timer_q   <= '0;
            ptr_q     <= 2'd0;
            win_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            lockout_q <= lockout_d;
            busy_q    <= busy_d;
            scores_q  <= scores_d;
            timer_q   <= timer_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
        end
    end

    assign lights  = lights_q;
    assign lockout = lockout_q;
    assign busy    = busy_q;
    assign scores  = scores_q;

endmodule

// File: tb/tb_jepardy_round_ctrl.sv
// tb/tb_jepardy_round_ctrl.sv - directed self-checking bench for jepardy_round_ctrl

module tb_jepardy_round_ctrl;

    logic        clock;
    logic        reset;
    logic        arm;
    logic [2:0]  P_button;
    logic        judge_ok;
    logic        judge_wrong;
    logic        clear_scores;
    logic [2:0]  lights;
    logic [2:0]  lockout;
    logic        busy;
    logic [11:0] scores;

    int passed = 0;
    int total  = 0;

    jepardy_round_ctrl #(
        .ANSWER_TICKS (4),
        .OPEN_TICKS   (8),
        .SCORE_W      (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .P_button     (P_button),
        .judge_ok     (judge_ok),
        .judge_wrong  (judge_wrong),
        .clear_scores (clear_scores),
        .lights       (lights),
        .lockout      (lockout),
        .busy         (busy),
        .scores       (scores)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
    endtask

    task automatic press(input logic [2:0] p);
        P_button = p;
        cyc(1);
        P_button = 3'b000;
    endtask

    task automatic judge(input logic ok, input logic wrong);
        judge_ok    = ok;
        judge_wrong = wrong;
        cyc(1);
        judge_ok    = 1'b0;
        judge_wrong = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        P_button     = 3'b000;
        judge_ok     = 1'b0;
        judge_wrong  = 1'b0;
        clear_scores = 1'b0;
        cyc(2);
        reset = 1'b0;

        check("reset_lights",  16'(lights),  16'h0);
        check("reset_lockout", 16'(lockout), 16'h0);
        check("reset_busy",    16'(busy),    16'h0);
        check("reset_scores",  16'(scores),  16'h0);

        // Buttons in IDLE are ignored
        press(3'b111);
        check("idle_btn_lights", 16'(lights), 16'h0);
        check("idle_btn_busy",   16'(busy),   16'h0);

        // 1: single press, judged correct
        do_arm();
        check("t1_open_busy", 16'(busy), 16'h1);
        press(3'b010);
        check("t1_lights", 16'(lights), 16'h2);
        judge(1'b1, 1'b0);
        check("t1_scores", 16'(scores), 16'h010);
        check("t1_lights_idle", 16'(lights), 16'h0);
        check("t1_busy_idle", 16'(busy), 16'h0);

        // 2: round-robin across three simultaneous presses
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        do_arm();
        press(3'b111);
        check("t2_rr_first", 16'(lights), 16'h1);
        judge(1'b1, 1'b0);
        do_arm();
        press(3'b111);
        check("t2_rr_second", 16'(lights), 16'h2);
        judge(1'b1, 1'b0);
        do_arm();
        press(3'b111);
        check("t2_rr_third", 16'(lights), 16'h4);
        judge(1'b1, 1'b0);
        check("t2_scores", 16'(scores), 16'h111);

        // 3: wrong answer locks the player out
        do_arm();
        press(3'b001);
        judge(1'b0, 1'b1);
        check("t3_lockout", 16'(lockout), 16'h1);
        check("t3_busy_open", 16'(busy), 16'h1);
        check("t3_lights_open", 16'(lights), 16'h0);
        P_button = 3'b001;
        cyc(2);
        check("t3_locked_no_grant", 16'(lights), 16'h0);
        P_button = 3'b100;
        cyc(1);
        P_button = 3'b000;
        check("t3_other_grant", 16'(lights), 16'h4);
        judge(1'b1, 1'b0);
        check("t3_scores", 16'(scores), 16'h211);

        // 4: answer timeout after exactly 4 cycles
        do_arm();
        press(3'b010);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_lights_held_%0d", i), 16'(lights), 16'h2);
            cyc(1);
        end
        check("t4_lights_after", 16'(lights), 16'h0);
        check("t4_lockout", 16'(lockout), 16'h2);
        check("t4_busy_open", 16'(busy), 16'h1);
        cyc(7);
        check("t4_open_still", 16'(busy), 16'h1);
        cyc(1);
        check("t4_open_expired", 16'(busy), 16'h0);

        // 5: lock out all three
        do_arm();
        check("t5_arm_clears_lockout", 16'(lockout), 16'h0);
        press(3'b001);
        judge(1'b0, 1'b1);
        press(3'b010);
        check("t5_p2_grant", 16'(lights), 16'h2);
        judge(1'b0, 1'b1);
        check("t5_lockout_two", 16'(lockout), 16'h3);
        press(3'b100);
        judge(1'b0, 1'b1);
        check("t5_all_locked_busy", 16'(busy), 16'h0);
        check("t5_all_locked_lockout", 16'(lockout), 16'h7);
        cyc(2);
        check("t5_lockout_held", 16'(lockout), 16'h7);
        do_arm();
        check("t5_rearm_lockout", 16'(lockout), 16'h0);
        cyc(7);
        check("t5_open_7", 16'(busy), 16'h1);
        cyc(1);
        check("t5_open_8", 16'(busy), 16'h0);

        // 6: score saturation, reset mid-answer, arm beats clear_scores
        for (int i = 0; i < 16; i++) begin
            do_arm();
            press(3'b001);
            judge(1'b1, 1'b0);
        end
        check("t6_saturate", 16'(scores), 16'h21F);
        do_arm();
        press(3'b001);
        check("t6_answer_before_reset", 16'(lights), 16'h1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_reset_lights",  16'(lights),  16'h0);
        check("t6_reset_lockout", 16'(lockout), 16'h0);
        check("t6_reset_busy",    16'(busy),    16'h0);
        check("t6_reset_scores",  16'(scores),  16'h0);
        do_arm();
        press(3'b010);
        judge(1'b1, 1'b0);
        arm          = 1'b1;
        clear_scores = 1'b1;
        cyc(1);
        arm          = 1'b0;
        clear_scores = 1'b0;
        check("t6_arm_clear_busy", 16'(busy), 16'h1);
        check("t6_arm_clear_scores", 16'(scores), 16'h010);
        cyc(8);
        clear_scores = 1'b1;
        cyc(1);
        clear_scores = 1'b0;
        check("t6_clear_scores", 16'(scores), 16'h0);

        // Both judges at once: ok wins
        do_arm();
        press(3'b100);
        judge(1'b1, 1'b1);
        check("both_judge_scores", 16'(scores), 16'h100);
        check("both_judge_lockout", 16'(lockout), 16'h0);
        check("both_judge_busy", 16'(busy), 16'h0);

        // Judge on the timeout edge: judge wins
        do_arm();
        press(3'b001);
        cyc(3);
        judge(1'b1, 1'b0);
        check("edge_judge_scores", 16'(scores), 16'h101);
        check("edge_judge_lockout", 16'(lockout), 16'h0);
        check("edge_judge_busy", 16'(busy), 16'h0);

        // Re-entry to OPEN with a held eligible button grants next edge
        do_arm();
        P_button = 3'b011;
        cyc(1);
        check("held_first", 16'(lights), 16'h2);
        judge_wrong = 1'b1;
        cyc(1);
        judge_wrong = 1'b0;
        check("held_reopen_lights", 16'(lights), 16'h0);
        cyc(1);
        P_button = 3'b000;
        check("held_regrant", 16'(lights), 16'h1);
        judge(1'b1, 1'b0);
        check("held_scores", 16'(scores), 16'h102);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
